// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction cache: word type, address split, frame layout, FSM states.
// Widths here describe the default 16-frame configuration.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned IIDX_W = 4;
    localparam int unsigned ITAG_W = 30 - IIDX_W;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;

    typedef enum logic {
        IDLE,
        MISS
    } icache_state_t;

endpackage

// File: rtl/icache_frame_array.sv
// Direct-mapped frame storage: asynchronous read by index, synchronous single-port write.
// Only the valid bits are reset; tag and data come up undefined.
module icache_frame_array
    import cpu_types_pkg::*;
#(
    parameter int unsigned NUM_SETS = 16,
    parameter int unsigned IDX_W    = $clog2(NUM_SETS),
    parameter int unsigned TAG_W    = 30 - IDX_W
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [IDX_W-1:0] i_ridx,
    output logic             o_valid,
    output logic [TAG_W-1:0] o_tag,
    output word_t            o_data,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  logic [TAG_W-1:0] i_wtag,
    input  word_t            i_wdata
);

    logic [NUM_SETS-1:0] r_valid;
    logic [TAG_W-1:0]    r_tag  [NUM_SETS];
    word_t               r_data [NUM_SETS];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_widx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_tag[i_widx]  <= i_wtag;
            r_data[i_widx] <= i_wdata;
        end
    end

    assign o_valid = r_valid[i_ridx];
    assign o_tag   = r_tag[i_ridx];
    assign o_data  = r_data[i_ridx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with 0-cycle hits and a blocking refill.
// Define ICACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module icache
    import cpu_types_pkg::*;
#(
    parameter int unsigned NUM_SETS = 16
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output logic  ihit,
    output word_t imemload,
    output logic  iREN,
    output word_t iaddr,
    input  logic  iwait,
    input  word_t iload
`ifdef ICACHE_STATS_EN
    ,
    output word_t hit_count,
    output word_t miss_count
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int unsigned TAG_W = 30 - IDX_W;

    icache_state_t    r_state, w_state_next;
    logic [29:0]      r_miss_addr;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_valid;
    logic [TAG_W-1:0] w_rtag;
    word_t            w_rdata;
    logic             w_hit;
    logic             w_miss;
    logic             w_fill;
    logic             w_unused_bytoff;

    assign w_idx           = imemaddr[1+IDX_W:2];
    assign w_tag           = imemaddr[31:2+IDX_W];
    assign w_unused_bytoff = ^imemaddr[1:0];

    icache_frame_array #(
        .NUM_SETS (NUM_SETS),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W)
    ) u_frames (
        .CLK     (CLK),
        .nRST    (nRST),
        .i_ridx  (w_idx),
        .o_valid (w_valid),
        .o_tag   (w_rtag),
        .o_data  (w_rdata),
        .i_we    (w_fill),
        .i_widx  (r_miss_addr[IDX_W-1:0]),
        .i_wtag  (r_miss_addr[29:IDX_W]),
        .i_wdata (iload)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_miss_addr <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_miss) begin
                r_miss_addr <= imemaddr[31:2];
            end
        end
    end

    // The refill always runs to completion; fetch redirects are only looked up back in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_hit        = 1'b0;
        w_miss       = 1'b0;
        w_fill       = 1'b0;
        iREN         = 1'b0;
        iaddr        = '0;
        unique case (r_state)
            IDLE: begin
                w_hit  = imemREN & w_valid & (w_rtag == w_tag);
                w_miss = imemREN & ~w_hit;
                if (w_miss) begin
                    w_state_next = MISS;
                end
            end
            MISS: begin
                iREN  = 1'b1;
                iaddr = {r_miss_addr, 2'b00};
                if (!iwait) begin
                    w_fill       = 1'b1;
                    w_state_next = IDLE;
                end
            end
        endcase
    end

    assign ihit     = w_hit;
    assign imemload = w_hit ? w_rdata : '0;

`ifdef ICACHE_STATS_EN
    word_t r_hit_count, r_miss_count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule
